// File: rtl/aes_round_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Stage codes, controller states and stage ordering for the AES
//            iterative round controller.
// Revision : 1.0
// ============================================================================
package aes_pkg;

  localparam int AES128_ROUNDS = 10;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_SUB   = 3'd1,
    OP_SHIFT = 3'd2,
    OP_MIX   = 3'd3,
    OP_ARK   = 3'd4
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT_ARK = 3'd1,
    ST_SUB      = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_MIX      = 3'd4,
    ST_ARK      = 3'd5,
    ST_DONE     = 3'd6
  } ctrl_state_t;

  // Stage that follows cur inside the rounds; OP_NONE means the block is finished.
  function automatic op_t next_op(input logic fwd, input op_t cur, input logic last_round);
    op_t nxt;
    nxt = OP_NONE;
    if (fwd) begin
      case (cur)
        OP_SUB:   nxt = OP_SHIFT;
        OP_SHIFT: nxt = last_round ? OP_ARK : OP_MIX;
        OP_MIX:   nxt = OP_ARK;
        OP_ARK:   nxt = last_round ? OP_NONE : OP_SUB;
        default:  nxt = OP_NONE;
      endcase
    end else begin
      case (cur)
        OP_SHIFT: nxt = OP_SUB;
        OP_SUB:   nxt = OP_ARK;
        OP_ARK:   nxt = last_round ? OP_NONE : OP_MIX;
        OP_MIX:   nxt = OP_SHIFT;
        default:  nxt = OP_NONE;
      endcase
    end
    return nxt;
  endfunction

  function automatic ctrl_state_t op_to_state(input op_t op);
    ctrl_state_t st;
    case (op)
      OP_SUB:   st = ST_SUB;
      OP_SHIFT: st = ST_SHIFT;
      OP_MIX:   st = ST_MIX;
      OP_ARK:   st = ST_ARK;
      default:  st = ST_DONE;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl_if
// Brief    : Start, key-request and result handshakes of the AES round controller.
// Revision : 1.0
// ============================================================================
interface aes_round_ctrl_if;
  logic       start_valid_i;
  logic       start_ready_o;
  logic       fwd_ninv_i;
  logic       abort_i;
  logic       key_req_o;
  logic [3:0] key_round_o;
  logic       key_ack_i;
  logic       out_valid_o;
  logic       out_ready_i;

  modport master (
    output start_valid_i, fwd_ninv_i, abort_i, key_ack_i, out_ready_i,
    input  start_ready_o, key_req_o, key_round_o, out_valid_o
  );

  modport slave (
    input  start_valid_i, fwd_ninv_i, abort_i, key_ack_i, out_ready_i,
    output start_ready_o, key_req_o, key_round_o, out_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_ctrl_stage_timer.sv
`default_nettype none
// ============================================================================
// Module   : aes_stage_timer
// Brief    : Counts the STAGE_LAT cycles of a datapath stage from its strobe.
// Revision : 1.0
// ============================================================================
module aes_stage_timer #(
  parameter int STAGE_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic fire_i,
  output logic stage_en_o,
  output logic stage_done_o
);

  localparam int c_CNT_W = $clog2(STAGE_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_HOLD = c_CNT_W'(STAGE_LAT - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clear_i) begin
      r_cnt <= '0;
    end else if (fire_i) begin
      r_cnt <= c_HOLD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - c_ONE;
    end
  end

  // A single-cycle stage ends in the same cycle as its strobe.
  assign stage_en_o   = fire_i;
  assign stage_done_o = fire_i ? (STAGE_LAT == 1) : (r_cnt == c_ONE);

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_ctrl
// Brief    : Iterative AES round sequencer driving the registered round datapath.
// Revision : 1.0
// ============================================================================
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int STAGE_LAT  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  aes_round_ctrl_if.slave        bus,
  output logic                   fwd_ninv_o,
  output op_t                    op_o,
  output logic                   stage_en_o,
  output logic                   load_o,
  output logic [3:0]             round_o,
  output logic                   busy_o
);

  localparam logic [3:0] c_NUM_ROUNDS = 4'(NUM_ROUNDS);

  ctrl_state_t r_state;
  op_t         r_op;
  logic        r_fwd;
  logic [3:0]  r_round;
  logic [3:0]  r_key_round;
  logic        r_armed;
  logic        r_key_req;
  logic        r_out_valid;
  logic        r_start_ready;
  logic        r_busy;

  logic        w_is_ark;
  logic        w_fire;
  logic        w_stage_en;
  logic        w_done;
  logic        w_last;
  logic        w_round_adv;
  logic [3:0]  w_next_round;
  op_t         w_next_op;

  // ARK stages fire on the key acknowledge; abort suppresses any strobe.
  always_comb begin
    w_is_ark     = (r_state == ST_INIT_ARK) || (r_state == ST_ARK);
    w_fire       = r_armed && (!w_is_ark || bus.key_ack_i) && !bus.abort_i;
    w_last       = (r_round == c_NUM_ROUNDS);
    w_next_op    = (r_state == ST_INIT_ARK) ? (r_fwd ? OP_SUB : OP_SHIFT)
                                            : next_op(r_fwd, r_op, w_last);
    w_round_adv  = (r_state == ST_INIT_ARK) ||
                   (r_fwd ? (r_op == OP_ARK) : (r_op == OP_MIX));
    w_next_round = w_round_adv ? (r_round + 4'd1) : r_round;
  end

  aes_stage_timer #(
    .STAGE_LAT (STAGE_LAT)
  ) u_stage_timer (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (bus.abort_i),
    .fire_i       (w_fire),
    .stage_en_o   (w_stage_en),
    .stage_done_o (w_done)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_NONE;
      r_fwd         <= 1'b1;
      r_round       <= '0;
      r_key_round   <= '0;
      r_armed       <= 1'b0;
      r_key_req     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else if (bus.abort_i && (r_state != ST_IDLE)) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_NONE;
      r_round       <= '0;
      r_key_round   <= '0;
      r_armed       <= 1'b0;
      r_key_req     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start_valid_i && r_start_ready) begin
            r_state       <= ST_INIT_ARK;
            r_op          <= OP_ARK;
            r_fwd         <= bus.fwd_ninv_i;
            r_round       <= '0;
            r_key_round   <= bus.fwd_ninv_i ? 4'd0 : c_NUM_ROUNDS;
            r_armed       <= 1'b1;
            r_key_req     <= 1'b1;
            r_start_ready <= 1'b0;
            r_busy        <= 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.out_ready_i) begin
            r_state       <= ST_IDLE;
            r_round       <= '0;
            r_key_round   <= '0;
            r_out_valid   <= 1'b0;
            r_start_ready <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
        default: begin
          if (w_fire) begin
            r_armed <= 1'b0;
          end
          if (w_done) begin
            if (w_next_op == OP_NONE) begin
              r_state     <= ST_DONE;
              r_op        <= OP_NONE;
              r_key_req   <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state     <= op_to_state(w_next_op);
              r_op        <= w_next_op;
              r_armed     <= 1'b1;
              r_key_req   <= (w_next_op == OP_ARK);
              r_round     <= w_next_round;
              r_key_round <= r_fwd ? w_next_round : (c_NUM_ROUNDS - w_next_round);
            end
          end
        end
      endcase
    end
  end

  assign fwd_ninv_o        = r_fwd;
  assign op_o              = r_op;
  assign stage_en_o        = w_stage_en;
  assign load_o            = w_stage_en && (r_state == ST_INIT_ARK);
  assign round_o           = r_round;
  assign busy_o            = r_busy;
  assign bus.start_ready_o = r_start_ready;
  assign bus.key_req_o     = r_key_req;
  assign bus.key_round_o   = r_key_round;
  assign bus.out_valid_o   = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_ctrl
// Brief    : Directed self-checking bench for aes_round_ctrl (STAGE_LAT 1 and 3).
// Revision : 1.0
// ============================================================================
module tb_aes_round_ctrl;

  localparam logic [2:0] T_NONE  = 3'd0;
  localparam logic [2:0] T_SUB   = 3'd1;
  localparam logic [2:0] T_SHIFT = 3'd2;
  localparam logic [2:0] T_MIX   = 3'd3;
  localparam logic [2:0] T_ARK   = 3'd4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  aes_round_ctrl_if bus1 ();
  aes_round_ctrl_if bus3 ();

  logic       fwd1, se1, ld1, busy1;
  logic [2:0] op1;
  logic [3:0] rnd1;
  logic       fwd3, se3, ld3, busy3;
  logic [2:0] op3;
  logic [3:0] rnd3;

  aes_round_ctrl #(.NUM_ROUNDS(10), .STAGE_LAT(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1), .fwd_ninv_o(fwd1), .op_o(op1),
    .stage_en_o(se1), .load_o(ld1), .round_o(rnd1), .busy_o(busy1)
  );

  aes_round_ctrl #(.NUM_ROUNDS(10), .STAGE_LAT(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus3), .fwd_ninv_o(fwd3), .op_o(op3),
    .stage_en_o(se3), .load_o(ld3), .round_o(rnd3), .busy_o(busy3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] exp_op  [40];
  logic [3:0] exp_key [40];
  logic [3:0] exp_rnd [40];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic build_seq(input bit fwd);
    int i;
    int st;
    exp_op[0] = T_ARK; exp_key[0] = fwd ? 4'd0 : 4'd10; exp_rnd[0] = 4'd0;
    i = 1;
    for (int r = 1; r <= 10; r++) begin
      st = i;
      if (fwd) begin
        exp_op[i] = T_SUB; exp_op[i+1] = T_SHIFT; i += 2;
        if (r < 10) begin exp_op[i] = T_MIX; i++; end
        exp_op[i] = T_ARK; exp_key[i] = 4'(r); i++;
      end else begin
        exp_op[i] = T_SHIFT; exp_op[i+1] = T_SUB; exp_op[i+2] = T_ARK;
        exp_key[i+2] = 4'(10 - r); i += 3;
        if (r < 10) begin exp_op[i] = T_MIX; i++; end
      end
      for (int k = st; k < i; k++) exp_rnd[k] = 4'(r);
    end
  endtask

  task automatic check_reset1(input string tag);
    check({tag, " start_ready"}, bus1.start_ready_o, 1);
    check({tag, " fwd_ninv"},    fwd1, 1);
    check({tag, " op"},          op1, T_NONE);
    check({tag, " round"},       rnd1, 0);
    check({tag, " key_round"},   bus1.key_round_o, 0);
    check({tag, " busy"},        busy1, 0);
    check({tag, " out_valid"},   bus1.out_valid_o, 0);
    check({tag, " key_req"},     bus1.key_req_o, 0);
    check({tag, " stage_en"},    se1, 0);
    check({tag, " load"},        ld1, 0);
  endtask

  task automatic start1(input bit fwd);
    @(posedge clk); #1;
    bus1.start_valid_i = 1'b1; bus1.fwd_ninv_i = fwd;
    @(negedge clk);
    check("start_ready idle", bus1.start_ready_o, 1);
    @(posedge clk); #1;
    bus1.start_valid_i = 1'b0; bus1.fwd_ninv_i = ~fwd;
  endtask

  // Walks one block from its first stage cycle; returns the cycle index reached.
  task automatic run1(input bit fwd, input int dly_idx, input int dly, input int abort_idx,
                      output int cyc);
    int  s;
    int  w;
    bit  ack;
    s = 0; w = 0; cyc = 1;
    build_seq(fwd);
    while (s < 40 && cyc < 300) begin
      ack = !(s == dly_idx && w < dly);
      bus1.key_ack_i = ack;
      bus1.abort_i   = (s == abort_idx);
      @(negedge clk);
      check($sformatf("op c%0d", cyc),       op1, exp_op[s]);
      check($sformatf("fwd c%0d", cyc),      fwd1, fwd);
      check($sformatf("round c%0d", cyc),    rnd1, exp_rnd[s]);
      check($sformatf("key_req c%0d", cyc),  bus1.key_req_o, exp_op[s] == T_ARK);
      check($sformatf("stage_en c%0d", cyc), se1, ack && (s != abort_idx));
      check($sformatf("load c%0d", cyc),     ld1, ack && (s == 0) && (s != abort_idx));
      check($sformatf("out_valid c%0d", cyc), bus1.out_valid_o, 0);
      if (exp_op[s] == T_ARK)
        check($sformatf("key_round c%0d", cyc), bus1.key_round_o, exp_key[s]);
      @(posedge clk); #1;
      cyc++;
      if (s == abort_idx) begin
        bus1.abort_i = 1'b0;
        s = 100;
      end else if (ack) begin
        s++;
      end else begin
        w++;
      end
    end
    bus1.key_ack_i = 1'b1;
  endtask

  task automatic check_done1(input string tag, input int cyc, input int want_cyc);
    @(negedge clk);
    check({tag, " latency"},     cyc, want_cyc);
    check({tag, " out_valid"},   bus1.out_valid_o, 1);
    check({tag, " start_ready"}, bus1.start_ready_o, 0);
    check({tag, " done op"},     op1, T_NONE);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, " out_valid drop"}, bus1.out_valid_o, 0);
    check({tag, " back idle"},      bus1.start_ready_o, 1);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus1.start_valid_i = 0; bus1.fwd_ninv_i = 1; bus1.abort_i = 0;
    bus1.key_ack_i = 1; bus1.out_ready_i = 1;
    bus3.start_valid_i = 0; bus3.fwd_ninv_i = 1; bus3.abort_i = 0;
    bus3.key_ack_i = 1; bus3.out_ready_i = 1;
    @(posedge clk); @(posedge clk); #1;
    check_reset1("reset");
    rst_n = 1'b1;

    // Encrypt and decrypt, key always available.
    start1(1'b1);
    run1(1'b1, -1, 0, -1, cyc);
    check_done1("enc", cyc, 41);
    start1(1'b0);
    run1(1'b0, -1, 0, -1, cyc);
    check_done1("dec", cyc, 41);

    // Round-5 ARK key arrives three cycles late.
    start1(1'b1);
    run1(1'b1, 20, 3, -1, cyc);
    check_done1("keydly", cyc, 44);

    // Three-cycle stages.
    build_seq(1'b1);
    @(posedge clk); #1;
    bus3.start_valid_i = 1'b1; bus3.fwd_ninv_i = 1'b1;
    @(posedge clk); #1;
    bus3.start_valid_i = 1'b0; bus3.fwd_ninv_i = 1'b0;
    for (int c = 1; c <= 120; c++) begin
      @(negedge clk);
      check($sformatf("lat3 op c%0d", c), op3, exp_op[(c-1)/3]);
      check($sformatf("lat3 stage_en c%0d", c), se3, ((c-1) % 3) == 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("lat3 out_valid", bus3.out_valid_o, 1);
    check("lat3 fwd", fwd3, 1);
    @(posedge clk); #1;

    // Consumer stalls while a new request is already waiting.
    bus1.out_ready_i = 1'b0;
    start1(1'b1);
    run1(1'b1, -1, 0, -1, cyc);
    bus1.start_valid_i = 1'b1; bus1.fwd_ninv_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall out_valid %0d", k), bus1.out_valid_o, 1);
      check($sformatf("stall start_ready %0d", k), bus1.start_ready_o, 0);
      @(posedge clk); #1;
    end
    bus1.out_ready_i = 1'b1;
    @(negedge clk);
    check("exit out_valid", bus1.out_valid_o, 1);
    check("exit start_ready", bus1.start_ready_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle start_ready", bus1.start_ready_o, 1);
    check("idle busy", busy1, 0);
    check("idle out_valid", bus1.out_valid_o, 0);
    @(posedge clk); #1;
    bus1.start_valid_i = 1'b0; bus1.fwd_ninv_i = 1'b0;

    // Abort the accepted block in round-3 MIX together with a key ack.
    run1(1'b1, -1, 0, 11, cyc);
    @(negedge clk);
    check("abort busy", busy1, 0);
    check("abort op", op1, T_NONE);
    check("abort start_ready", bus1.start_ready_o, 1);
    check("abort out_valid", bus1.out_valid_o, 0);
    check("abort stage_en", se1, 0);
    check("abort key_req", bus1.key_req_o, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort quiet stage_en", se1, 0);
    check("abort quiet busy", busy1, 0);

    // Asynchronous reset in the middle of a decrypt block.
    start1(1'b0);
    repeat (7) @(posedge clk);
    #3;
    check("pre-reset busy", busy1, 1);
    check("pre-reset fwd", fwd1, 0);
    rst_n = 1'b0;
    #1;
    check_reset1("async reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Iterative AES round sequencer for the registered round datapath: sub_bytes, shift_rows, mix_columns and add_round_key.
- Accepts one block request, latches the direction, and steps the datapath one stage at a time.
- Requests round keys from the key schedule and asserts a valid/ready result handshake.
- Sits between the bus-facing command logic and the datapath. It drives only control; it never touches the 128-bit state.

Parameters:
NUM_ROUNDS, 10, cipher rounds (10 for AES-128; 12 and 14 are legal).
STAGE_LAT, 1, cycles each registered datapath stage occupies (>=1).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
start_valid_i  in  1  block request.
start_ready_o  out  1  high only in IDLE.
fwd_ninv_i  in  1  direction, sampled on start handshake (1 = encrypt).
abort_i  in  1  synchronous abort of the current block.
fwd_ninv_o  out  1  latched direction, drives every datapath stage.
op_o  out  3  current stage code (package enum).
stage_en_o  out  1  one-cycle strobe, first cycle of each stage.
load_o  out  1  datapath takes the input block (initial ARK only).
round_o  out  4  current round, 0 = initial ARK.
key_req_o  out  1  key request, held during ARK states.
key_round_o  out  4  requested round-key index.
key_ack_i  in  1  requested key is valid this cycle.
out_valid_o  out  1  result ready.
out_ready_i  in  1  consumer accepts result.
busy_o  out  1  state != IDLE.

Behaviour:
- Reset values (async, immediate): state IDLE, start_ready_o=1, fwd_ninv_o=1, op_o=OP_NONE, round_o=0, key_round_o=0, all other outputs 0.
- Start handshake: start_valid_i & start_ready_o at edge E. Latch the direction. The INIT_ARK stage begins in the cycle after E.
- Encrypt order:
  - INIT_ARK (key 0).
  - Rounds 1..NUM_ROUNDS-1: SUB, SHIFT, MIX, ARK.
  - Final round: SUB, SHIFT, ARK (no MIX).
- Decrypt order:
  - INIT_ARK (key NUM_ROUNDS).
  - Rounds 1..NUM_ROUNDS-1: SHIFT, SUB, ARK, MIX.
  - Final round: SHIFT, SUB, ARK.
  - In decrypt, op codes mean the inverse operation via fwd_ninv_o=0.
- Key index:
  - Encrypt: key_round_o = round_o.
  - Decrypt: key_round_o = NUM_ROUNDS - round_o.
- Non-ARK stages last exactly STAGE_LAT cycles. op_o is held for the whole stage; stage_en_o is high in its first cycle only.
- ARK stages:
  - key_req_o is high from the first cycle of the state.
  - stage_en_o pulses only in the cycle key_ack_i=1; then STAGE_LAT-1 further hold cycles follow.
  - Wait for ack is unbounded; no timeout.
- load_o equals stage_en_o during INIT_ARK and is 0 otherwise.
- round_o increments when the stage after the last stage of a round begins. Wrap is impossible: the counter never exceeds NUM_ROUNDS.
- Latency with STAGE_LAT=1, NUM_ROUNDS=10 and key_ack_i tied high:
  - 40 stage cycles.
  - out_valid_o rises in cycle E+41.
  - Both directions are equal.
- DONE state:
  - out_valid_o held until out_ready_i. On handshake, the next state is IDLE.
  - start_ready_o is 0 in DONE, so there is no overlap. start_valid_i in the DONE-exit cycle is not accepted.
- abort_i:
  - Any non-IDLE state goes to IDLE next edge.
  - op_o=OP_NONE, out_valid_o=0, no further strobes.
  - Abort beats a simultaneous key_ack_i or out_ready_i. Abort in IDLE is ignored.
- fwd_ninv_i changes after the handshake have no effect until the next start.
- Reset mid-operation: immediate return to reset values; no result is produced.
- FSM states: IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK, DONE. A stage counter (ceil(log2(STAGE_LAT+1)) bits) and a round counter run alongside.

Decomposition:
- Package aes_pkg holds:
  - the op_t enum (OP_NONE=0, OP_SUB=1, OP_SHIFT=2, OP_MIX=3, OP_ARK=4);
  - the ctrl_state_t enum;
  - AES128_ROUNDS=10.
- The next-stage ordering function (direction, current op, final-round flag -> next op) goes in the package too.
- Sub-module aes_stage_timer: STAGE_LAT down-counter producing stage_en and stage_done. The FSM stays in aes_round_ctrl.

Test Plan:
- Encrypt, STAGE_LAT=1, key_ack_i=1, out_ready_i=1 -> op_o sequence ARK, then (SUB,SHIFT,MIX,ARK)x9, then SUB,SHIFT,ARK. key_round_o on ARKs = 0..10; out_valid_o at E+41 for one cycle.
- Decrypt, same setup -> op_o sequence ARK, then (SHIFT,SUB,ARK,MIX)x9, then SHIFT,SUB,ARK. key_round_o on ARKs = 10..0; fwd_ninv_o=0 throughout.
- key_ack_i delayed 3 cycles on round-5 ARK -> key_req_o held 4 cycles, single stage_en_o pulse on the ack cycle, total latency 44.
- STAGE_LAT=3 encrypt -> each op_o held 3 cycles, stage_en_o every 3rd cycle, out_valid_o at E+121.
- out_ready_i low for 5 cycles in DONE while start_valid_i=1 -> out_valid_o held, start_ready_o=0; the new block is accepted on the first IDLE cycle.
- abort_i during round 3 MIX together with key_ack_i=1, then rst_ni pulsed low mid-block on the next run -> IDLE next edge with no strobe; all outputs at reset values asynchronously.
